// File: rtl/psum_acc_fifo.sv
// Multi-lane partial-sum FIFO: each write stores the raw PE result or the result plus an
// incoming partial sum (saturating or wrapping), with status, sticky error flags and sync clear.
module psum_acc_fifo #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_CH     = 4,
    parameter int DEPTH      = 10,
    parameter int ADDR_WIDTH = 4,
    parameter int SATURATE   = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clr,
    input  logic                         wr_en,
    input  logic                         acc_en,
    input  logic [NUM_CH*DATA_WIDTH-1:0] wr_data,
    input  logic [NUM_CH*DATA_WIDTH-1:0] psum_in,
    input  logic                         rd_en,
    output logic [NUM_CH*DATA_WIDTH-1:0] rd_data,
    output logic                         rd_valid,
    output logic                         full,
    output logic                         empty,
    output logic [ADDR_WIDTH:0]          count,
    output logic                         ovf_err,
    output logic                         udf_err,
    output logic                         sat_flag
);

    localparam int                    W         = NUM_CH * DATA_WIDTH;
    localparam logic [ADDR_WIDTH:0]   DEPTH_CNT = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_PTR  = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [DATA_WIDTH-1:0] MAX_VAL   = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] MIN_VAL   = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    logic [W-1:0]            mem [DEPTH];
    logic [ADDR_WIDTH-1:0]   rd_ptr;
    logic [ADDR_WIDTH-1:0]   wr_ptr;
    logic                    rd_acc;
    logic                    wr_acc;
    logic [W-1:0]            wr_word;
    logic                    sat_hit;
    logic [DATA_WIDTH-1:0]   lane_a;
    logic [DATA_WIDTH-1:0]   lane_b;
    logic [DATA_WIDTH:0]     lane_sum;

    assign full   = (count == DEPTH_CNT);
    assign empty  = (count == '0);
    assign rd_acc = rd_en & ~empty & ~clr;
    // A read accepted in the same cycle frees the slot, so a full FIFO still takes the write.
    assign wr_acc = wr_en & (~full | rd_acc) & ~clr;

    always_comb begin
        wr_word  = '0;
        sat_hit  = 1'b0;
        lane_a   = '0;
        lane_b   = '0;
        lane_sum = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            lane_a   = wr_data[i*DATA_WIDTH +: DATA_WIDTH];
            lane_b   = psum_in[i*DATA_WIDTH +: DATA_WIDTH];
            lane_sum = {lane_a[DATA_WIDTH-1], lane_a} + {lane_b[DATA_WIDTH-1], lane_b};
            if (!acc_en) begin
                wr_word[i*DATA_WIDTH +: DATA_WIDTH] = lane_a;
            end else if ((SATURATE != 0) && (lane_sum[DATA_WIDTH] != lane_sum[DATA_WIDTH-1])) begin
                // Extra sign bit disagreeing with the lane MSB means the sum left the signed range.
                wr_word[i*DATA_WIDTH +: DATA_WIDTH] = lane_sum[DATA_WIDTH] ? MIN_VAL : MAX_VAL;
                sat_hit = 1'b1;
            end else begin
                wr_word[i*DATA_WIDTH +: DATA_WIDTH] = lane_sum[DATA_WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= wr_word;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            ovf_err  <= 1'b0;
            udf_err  <= 1'b0;
            sat_flag <= 1'b0;
        end else if (clr) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            ovf_err  <= 1'b0;
            udf_err  <= 1'b0;
            sat_flag <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr   <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
                rd_data  <= mem[rd_ptr];
                rd_valid <= 1'b1;
            end else begin
                rd_data  <= '0;
                rd_valid <= 1'b0;
            end
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (wr_en & ~wr_acc) begin
                ovf_err <= 1'b1;
            end
            if (rd_en & ~rd_acc) begin
                udf_err <= 1'b1;
            end
            if (wr_acc & sat_hit) begin
                sat_flag <= 1'b1;
            end
        end
    end

endmodule
